ysyx_25040101_ifu: RTL and testbench
====================================

# ysyx_25040101_ifu

Instruction fetch unit of the multi-cycle nebula core, directly upstream of the decode stage's control unit. It holds the PC and issues one read per instruction to instruction memory over a valid/ready request and valid-only response channel. It presents the fetched word plus its PC to decode over a valid/ready handshake, then waits for the next PC from the execute/writeback path before fetching again. It also detects misaligned targets and memory timeouts.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 255, max cycles from request acceptance to response before a timeout error (1..255)
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid_o  out  1  read request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_addr_o  out  32  request address (= current PC)
- imem_rsp_valid_i  in  1  response valid (single cycle, no backpressure)
- imem_rsp_data_i  in  32  fetched instruction word
- imem_rsp_err_i  in  1  bus error qualifier for response
- inst_valid_o  out  1  instruction available to decode
- inst_ready_i  in  1  decode consumes instruction
- inst_o  out  32  instruction word (opcode in [6:0], func3 in [14:12], func7 bit in [30])
- pc_o  out  32  PC of inst_o
- fetch_err_o  out  1  qualifies inst_o as faulting (misaligned, bus error or timeout)
- err_code_o  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout
- dnpc_valid_i  in  1  next PC available
- dnpc_i  in  32  next PC

## Operation
- State machine with states REQ, WAIT, DELIVER and NPC. Reset enters REQ.
- REQ: imem_req_valid_o=1 and imem_addr_o=pc.
  - If pc[1:0]!=0, no request is issued. Go to DELIVER with fetch_err_o=1, err_code_o=1, inst_o=0.
  - On imem_req_valid_o && imem_req_ready_i, go to WAIT and clear the timeout counter.
  - imem_req_valid_o and imem_addr_o hold stable until accepted.
- WAIT: the 8-bit counter increments each cycle without a response.
  - On imem_rsp_valid_i, latch data and err into the output register and go to DELIVER. If imem_rsp_err_i=1, err_code_o=2 and fetch_err_o=1.
  - If the counter reaches TIMEOUT with no response, go to DELIVER with err_code_o=3 and inst_o=0.
  - A response arriving after timeout, while not in WAIT, is ignored.
- DELIVER: inst_valid_o=1.
  - inst_o, pc_o, fetch_err_o and err_code_o hold stable until inst_valid_o && inst_ready_i.
  - Then go to NPC.
- NPC: waits for dnpc_valid_i; when it is seen, load pc<=dnpc_i and go to REQ.
  - dnpc_valid_i in any other state is ignored; this is a single-outstanding design.
- Responses are accepted only in WAIT. Requests are issued only in REQ.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, counter=0.
  - inst_o=0, pc_o=RESET_PC, fetch_err_o=0, err_code_o=0.
  - inst_valid_o=0, imem_req_valid_o=0 during the reset cycle.
- The first request is asserted in the first cycle after rst deasserts.
- Best-case fetch latency:
  - Request accepted in cycle N.
  - Response in N+1.
  - inst_valid_o high in N+2.
  - Each FSM transition costs exactly one cycle; there are no combinational paths from responses to inst_valid_o.
- A zero-wait response is impossible by protocol. A response in the same cycle as request acceptance is ignored.
- Misaligned PC: inst_valid_o is asserted one cycle after entering REQ, and imem_req_valid_o stays 0.
- dnpc seen in cycle M leads to imem_req_valid_o with the new address in M+1.
- Timeout: entering WAIT at cycle N with no response gives inst_valid_o at N+TIMEOUT+1.
- rst asserted in any state, including mid-WAIT, returns to the reset values next edge. Any in-flight response is discarded.

## Test plan
- Reset then immediate ready; response 32'h0010_0093 (addi) one cycle later -> imem_addr_o=8000_0000, inst_valid_o at cycle 2, inst_o=0010_0093, pc_o=8000_0000, err_code_o=0.
- Hold imem_req_ready_i=0 for 5 cycles -> imem_req_valid_o stays 1 with a stable address. Hold inst_ready_i=0 for 4 cycles in DELIVER -> outputs stable, no new request.
- dnpc_i=8000_0004 after delivery -> the next request address is 8000_0004 exactly one cycle after dnpc_valid_i.
- dnpc_i=8000_0002 -> no memory request, inst_valid_o with fetch_err_o=1, err_code_o=1. A response with imem_rsp_err_i=1 -> err_code_o=2.
- With TIMEOUT=4, no response -> err_code_o=3 after 4 WAIT cycles. A late response 2 cycles afterwards is ignored, and inst_o stays 0.
- Assert rst mid-WAIT and deliver a response in the next cycle -> the response is discarded, and the fetch restarts at 8000_0000.

Source files
------------

// File: rtl/ysyx_25040101_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_ifu -- instruction fetch unit of the multi-cycle nebula core.
//
// Holds the PC, issues one instruction-memory read per instruction, hands the
// fetched word and its PC to decode, then waits for the next PC before the
// following fetch. Misaligned targets, bus errors and response timeouts are
// reported alongside the delivered (possibly zeroed) instruction word.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   TIMEOUT   cycles counted in WAIT before a timeout is declared (1..255)
//
// Ports
//   clk, rst           core clock; synchronous active-high reset
//   imem_req_*         request channel (valid/ready), address = current PC
//   imem_rsp_*         response channel (valid only, one cycle, no backpressure)
//   inst_valid_o/inst_ready_i, inst_o, pc_o, fetch_err_o, err_code_o
//                      delivery to decode (valid/ready, held until accepted)
//   dnpc_valid_i, dnpc_i
//                      next PC from execute/writeback, taken only in NPC
// ---------------------------------------------------------------------------
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fetch_err_o,
  output logic [1:0]  err_code_o,
  input  logic        dnpc_valid_i,
  input  logic [31:0] dnpc_i
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DELIVER,
    S_NPC
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [7:0]  r_cnt;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic        r_err;
  logic [1:0]  r_code;

  logic        w_misaligned;
  logic        w_load;
  logic [31:0] w_load_inst;
  logic        w_load_err;
  logic [1:0]  w_load_code;

  assign w_misaligned = (r_pc[1:0] != 2'b00);

  // Outputs are masked while rst is high so nothing is offered in the reset
  // cycle regardless of the state being left.
  assign imem_req_valid_o = !rst && (r_state == S_REQ) && !w_misaligned;
  assign imem_addr_o      = r_pc;
  assign inst_valid_o     = !rst && (r_state == S_DELIVER);
  assign inst_o           = r_inst;
  assign pc_o             = r_pc_out;
  assign fetch_err_o      = r_err;
  assign err_code_o       = r_code;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_inst = '0;
    w_load_err  = 1'b0;
    w_load_code = 2'd0;
    unique case (r_state)
      S_REQ: begin
        if (w_misaligned) begin
          w_state_nxt = S_DELIVER;
          w_load      = 1'b1;
          w_load_err  = 1'b1;
          w_load_code = 2'd1;
        end else if (imem_req_ready_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the counter's final cycle still wins over the timeout.
        if (imem_rsp_valid_i) begin
          w_state_nxt = S_DELIVER;
          w_load      = 1'b1;
          w_load_inst = imem_rsp_data_i;
          w_load_err  = imem_rsp_err_i;
          w_load_code = imem_rsp_err_i ? 2'd2 : 2'd0;
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_state_nxt = S_DELIVER;
          w_load      = 1'b1;
          w_load_err  = 1'b1;
          w_load_code = 2'd3;
        end
      end
      S_DELIVER: begin
        if (inst_ready_i) w_state_nxt = S_NPC;
      end
      S_NPC: begin
        if (dnpc_valid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_inst   <= '0;
      r_pc_out <= RESET_PC;
      r_err    <= 1'b0;
      r_code   <= 2'd0;
    end else begin
      // Counter sits at zero in REQ, so WAIT always starts from a clean count.
      if (r_state == S_REQ)       r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
      if (r_state == S_NPC && dnpc_valid_i) r_pc <= dnpc_i;
      if (w_load) begin
        r_inst   <= w_load_inst;
        r_pc_out <= r_pc;
        r_err    <= w_load_err;
        r_code   <= w_load_code;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
module tb_ysyx_25040101_ifu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;
  logic [1:0]  err_code_o;
  logic        dnpc_valid_i;
  logic [31:0] dnpc_i;

  ysyx_25040101_ifu #(.RESET_PC(32'h8000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .imem_rsp_err_i(imem_rsp_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .fetch_err_o(fetch_err_o), .err_code_o(err_code_o),
    .dnpc_valid_i(dnpc_valid_i), .dnpc_i(dnpc_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int unsigned req_stall;
    int unsigned rsp_dly;    // cycles after acceptance; 0 = no response
    logic [31:0] data;
    logic        rsp_err;
    logic        same_rsp;   // junk response in the acceptance cycle
    int unsigned rdy_stall;
    logic        late_rsp;   // stray response while delivering
    logic [31:0] e_inst;
    logic        e_err;
    logic [1:0]  e_code;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input vec_t v);
    int unsigned cyc;
    int unsigned exp_lat;
    exp_t e;
    sb.push_back('{inst: v.e_inst, pc: v.pc, err: v.e_err, code: v.e_code});
    if (v.pc[1:0] != 2'b00) begin
      chk("mis_noreq", 32'(imem_req_valid_o), 32'd0);
      chk("mis_notyet", 32'(inst_valid_o), 32'd0);
      @(negedge clk);
      chk("mis_valid", 32'(inst_valid_o), 32'd1);
      chk("mis_noreq2", 32'(imem_req_valid_o), 32'd0);
    end else begin
      chk("req_valid", 32'(imem_req_valid_o), 32'd1);
      chk("req_addr", imem_addr_o, v.pc);
      for (int unsigned k = 0; k < v.req_stall; k++) begin
        @(negedge clk);
        chk("stall_valid", 32'(imem_req_valid_o), 32'd1);
        chk("stall_addr", imem_addr_o, v.pc);
      end
      imem_req_ready_i = 1'b1;
      if (v.same_rsp) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hBAD0_BAD0;
        imem_rsp_err_i   = 1'b1;
      end
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_err_i   = 1'b0;
      chk("wait_noreq", 32'(imem_req_valid_o), 32'd0);
      exp_lat = (v.rsp_dly != 0) ? v.rsp_dly + 1 : TMO + 2;
      cyc = 1;
      while (!inst_valid_o && cyc < 40) begin
        if (cyc == v.rsp_dly) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = v.data;
          imem_rsp_err_i   = v.rsp_err;
        end
        @(negedge clk);
        imem_rsp_valid_i = 1'b0;
        imem_rsp_err_i   = 1'b0;
        cyc++;
      end
      chk("latency", 32'(cyc), 32'(exp_lat));
    end
    for (int unsigned k = 0; k < v.rdy_stall; k++) begin
      if (v.late_rsp && k == 1) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      imem_rsp_valid_i = 1'b0;
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_inst", inst_o, v.e_inst);
      chk("hold_noreq", 32'(imem_req_valid_o), 32'd0);
    end
    inst_ready_i = 1'b1;
    chk("hs_valid", 32'(inst_valid_o), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("inst", inst_o, e.inst);
      chk("pc", pc_o, e.pc);
      chk("err", 32'(fetch_err_o), 32'(e.err));
      chk("code", 32'(err_code_o), 32'(e.code));
    end
    @(negedge clk);
    inst_ready_i = 1'b0;
    chk("npc_novalid", 32'(inst_valid_o), 32'd0);
    chk("npc_noreq", 32'(imem_req_valid_o), 32'd0);
  endtask

  task automatic send_dnpc(input logic [31:0] a, input int unsigned idle);
    for (int unsigned k = 0; k < idle; k++) begin
      @(negedge clk);
      chk("idle_noreq", 32'(imem_req_valid_o), 32'd0);
    end
    dnpc_valid_i = 1'b1;
    dnpc_i       = a;
    @(negedge clk);
    dnpc_valid_i = 1'b0;
    dnpc_i       = 32'h1234_5678;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h8000_0000, 0, 1, 32'h0010_0093, 1'b0, 1'b0, 0, 1'b0, 32'h0010_0093, 1'b0, 2'd0};
    vecs[1] = '{32'h8000_0004, 5, 1, 32'h0020_0113, 1'b0, 1'b0, 4, 1'b0, 32'h0020_0113, 1'b0, 2'd0};
    vecs[2] = '{32'h8000_0002, 0, 0, 32'h0,         1'b0, 1'b0, 1, 1'b0, 32'h0,         1'b1, 2'd1};
    vecs[3] = '{32'h8000_0008, 0, 2, 32'h0000_0073, 1'b1, 1'b0, 0, 1'b0, 32'h0000_0073, 1'b1, 2'd2};
    vecs[4] = '{32'h8000_000C, 0, 0, 32'h0,         1'b0, 1'b0, 3, 1'b1, 32'h0,         1'b1, 2'd3};
    vecs[5] = '{32'h8000_0010, 1, 3, 32'h4000_0033, 1'b0, 1'b1, 0, 1'b0, 32'h4000_0033, 1'b0, 2'd0};
    vecs[6] = '{32'h8000_0014, 0, 4, 32'h00C5_8533, 1'b0, 1'b0, 2, 1'b0, 32'h00C5_8533, 1'b0, 2'd0};

    rst = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    imem_rsp_err_i   = 1'b0;
    inst_ready_i     = 1'b0;
    dnpc_valid_i     = 1'b0;
    dnpc_i           = '0;
    repeat (3) @(negedge clk);
    chk("rst_reqv", 32'(imem_req_valid_o), 32'd0);
    chk("rst_instv", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_err", 32'(fetch_err_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    rst = 1'b0;
    #1;

    for (int unsigned i = 0; i < 7; i++) begin
      if (i > 0) send_dnpc(vecs[i].pc, i % 3);
      do_fetch(vecs[i]);
    end

    // Reset in the middle of WAIT; the response that follows must be dropped.
    send_dnpc(32'h8000_0020, 0);
    chk("mw_addr", imem_addr_o, 32'h8000_0020);
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mw_rst_reqv", 32'(imem_req_valid_o), 32'd0);
    chk("mw_rst_instv", 32'(inst_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hCAFE_0000;
    #1;
    chk("mw_reqv", 32'(imem_req_valid_o), 32'd1);
    chk("mw_addr0", imem_addr_o, 32'h8000_0000);
    chk("mw_pc", pc_o, 32'h8000_0000);
    chk("mw_inst", inst_o, 32'd0);
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    chk("mw_drop", 32'(inst_valid_o), 32'd0);
    do_fetch('{32'h8000_0000, 0, 1, 32'h0000_0013, 1'b0, 1'b0, 1, 1'b0, 32'h0000_0013, 1'b0, 2'd0});

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
